// File: rtl/data_memory_dp.sv
// Dual-port data RAM: port A read/write with byte enables, port B read-only, post-reset clear.
// Optional macro DMEM_OUTREG_EN adds a second output register stage on both read ports.
module data_memory_dp #(
    parameter int unsigned ADDR_WIDTH     = 6,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned RD_MODE        = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    a_en_i,
    input  logic [DATA_WIDTH/8-1:0] a_we_i,
    input  logic [ADDR_WIDTH-1:0]   a_addr_i,
    input  logic [DATA_WIDTH-1:0]   a_di_i,
    output logic [DATA_WIDTH-1:0]   a_do_o,
    output logic                    a_vld_o,
    input  logic                    b_en_i,
    input  logic [ADDR_WIDTH-1:0]   b_addr_i,
    output logic [DATA_WIDTH-1:0]   b_do_o,
    output logic                    b_vld_o,
    output logic                    busy_o
);

    localparam int unsigned Depth    = 2 ** ADDR_WIDTH;
    localparam int unsigned NumBytes = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LastAddr = {ADDR_WIDTH{1'b1}};

    localparam int unsigned RdFirst  = 0;
    localparam int unsigned WrFirst  = 1;
    localparam int unsigned NoChange = 2;

    if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of 8");
    end
    if (RD_MODE > NoChange) begin : g_bad_mode
        $error("RD_MODE must be 0, 1 or 2");
    end

    typedef enum logic [0:0] {StClear, StReady} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
    logic                    busy;

    logic [DATA_WIDTH-1:0]   mem_q [Depth];

    logic [NumBytes-1:0]     wr_be;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;

    logic [DATA_WIDTH-1:0]   a_old;
    logic [DATA_WIDTH-1:0]   a_merged;
    logic                    a_fire;
    logic                    b_fire;

    logic [DATA_WIDTH-1:0]   a_do_q, a_do_d;
    logic                    a_vld_q, a_vld_d;
    logic [DATA_WIDTH-1:0]   b_do_q, b_do_d;
    logic                    b_vld_q, b_vld_d;

    assign busy   = (state_q == StClear);
    assign busy_o = busy;

    // Clear sequencer: one word per cycle, parks on the last address until the next reset.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        unique case (state_q)
            StClear: begin
                if (clr_addr_q == LastAddr) begin
                    state_d = StReady;
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
                end
            end
            StReady: begin
                state_d = StReady;
            end
            default: begin
                state_d = StReady;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? StClear : StReady;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    assign a_fire = a_en_i & ~busy;
    assign b_fire = b_en_i & ~busy;

    // Single write port shared by the clear sequencer and port A.
    always_comb begin
        wr_be   = '0;
        wr_addr = a_addr_i;
        wr_data = a_di_i;
        if (rst_ni) begin
            if (busy) begin
                wr_be   = {NumBytes{1'b1}};
                wr_addr = clr_addr_q;
                wr_data = '0;
            end else if (a_en_i) begin
                wr_be = a_we_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NumBytes; i++) begin
            if (wr_be[i]) begin
                mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    assign a_old = mem_q[a_addr_i];

    always_comb begin
        a_merged = a_old;
        for (int i = 0; i < NumBytes; i++) begin
            if (a_we_i[i]) begin
                a_merged[8*i +: 8] = a_di_i[8*i +: 8];
            end
        end
    end

    always_comb begin
        a_do_d  = a_do_q;
        a_vld_d = 1'b0;
        if (a_fire) begin
            if (a_we_i == '0) begin
                a_do_d  = a_old;
                a_vld_d = 1'b1;
            end else if (RD_MODE == WrFirst) begin
                a_do_d  = a_merged;
                a_vld_d = 1'b1;
            end else if (RD_MODE == RdFirst) begin
                a_do_d  = a_old;
                a_vld_d = 1'b1;
            end
        end
    end

    // Port B reads the array before this cycle's write lands, so collisions return old data.
    always_comb begin
        b_do_d  = b_do_q;
        b_vld_d = b_fire;
        if (b_fire) begin
            b_do_d = mem_q[b_addr_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            a_do_q  <= '0;
            a_vld_q <= 1'b0;
            b_do_q  <= '0;
            b_vld_q <= 1'b0;
        end else begin
            a_do_q  <= a_do_d;
            a_vld_q <= a_vld_d;
            b_do_q  <= b_do_d;
            b_vld_q <= b_vld_d;
        end
    end

`ifdef DMEM_OUTREG_EN
    logic [DATA_WIDTH-1:0] a_do2_q;
    logic                  a_vld2_q;
    logic [DATA_WIDTH-1:0] b_do2_q;
    logic                  b_vld2_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            a_do2_q  <= '0;
            a_vld2_q <= 1'b0;
            b_do2_q  <= '0;
            b_vld2_q <= 1'b0;
        end else begin
            a_do2_q  <= a_do_q;
            a_vld2_q <= a_vld_q;
            b_do2_q  <= b_do_q;
            b_vld2_q <= b_vld_q;
        end
    end

    assign a_do_o  = a_do2_q;
    assign a_vld_o = a_vld2_q;
    assign b_do_o  = b_do2_q;
    assign b_vld_o = b_vld2_q;
`else
    assign a_do_o  = a_do_q;
    assign a_vld_o = a_vld_q;
    assign b_do_o  = b_do_q;
    assign b_vld_o = b_vld_q;
`endif

endmodule

// File: tb/tb_data_memory_dp.sv
// Bench for data_memory_dp: three instances (RD_MODE 0/1/2) share stimulus and are
// compared every cycle against an array-based reference model plus directed checks.
module tb_data_memory_dp;

    localparam int AW    = 6;
    localparam int DW    = 16;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 2 ** AW;
`ifdef DMEM_OUTREG_EN
    localparam int Lat = 2;
`else
    localparam int Lat = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_en;
    logic [NB-1:0] a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_di;
    logic          b_en;
    logic [AW-1:0] b_addr;

    logic [DW-1:0] a_do  [3];
    logic          a_vld [3];
    logic [DW-1:0] b_do  [3];
    logic          b_vld [3];
    logic          busy  [3];

    always #5 clk = ~clk;

    for (genvar m = 0; m < 3; m++) begin : g_dut
        data_memory_dp #(
            .ADDR_WIDTH    (AW),
            .DATA_WIDTH    (DW),
            .RD_MODE       (m),
            .CLEAR_ON_RESET(1)
        ) u_dut (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .a_en_i  (a_en),
            .a_we_i  (a_we),
            .a_addr_i(a_addr),
            .a_di_i  (a_di),
            .a_do_o  (a_do[m]),
            .a_vld_o (a_vld[m]),
            .b_en_i  (b_en),
            .b_addr_i(b_addr),
            .b_do_o  (b_do[m]),
            .b_vld_o (b_vld[m]),
            .busy_o  (busy[m])
        );
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: whole-word array, a busy countdown, and per-mode read registers.
    logic [DW-1:0] mem_m [DEPTH];
    int            busy_left;
    logic [DW-1:0] ad1 [3], ad2 [3];
    logic          av1 [3], av2 [3];
    logic [DW-1:0] bd1, bd2;
    logic          bv1, bv2;

    task automatic model_edge();
        logic [DW-1:0] old_w, new_w;
        if (!rst_n) begin
            busy_left = DEPTH;
            for (int m = 0; m < 3; m++) begin
                ad1[m] = '0; ad2[m] = '0; av1[m] = 1'b0; av2[m] = 1'b0;
            end
            bd1 = '0; bd2 = '0; bv1 = 1'b0; bv2 = 1'b0;
        end else begin
            for (int m = 0; m < 3; m++) begin
                ad2[m] = ad1[m];
                av2[m] = av1[m];
            end
            bd2 = bd1;
            bv2 = bv1;
            if (busy_left > 0) begin
                for (int m = 0; m < 3; m++) av1[m] = 1'b0;
                bv1 = 1'b0;
                busy_left--;
                if (busy_left == 0) begin
                    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
                end
            end else begin
                old_w = mem_m[a_addr];
                new_w = old_w;
                for (int i = 0; i < NB; i++) begin
                    if (a_we[i]) new_w[8*i +: 8] = a_di[8*i +: 8];
                end
                bv1 = b_en;
                if (b_en) bd1 = mem_m[b_addr];
                for (int m = 0; m < 3; m++) begin
                    av1[m] = 1'b0;
                    if (a_en) begin
                        if (a_we == '0 || m == 0) begin
                            ad1[m] = old_w;
                            av1[m] = 1'b1;
                        end else if (m == 1) begin
                            ad1[m] = new_w;
                            av1[m] = 1'b1;
                        end
                    end
                end
                if (a_en) mem_m[a_addr] = new_w;
            end
        end
    endtask

    task automatic check_outputs();
        for (int m = 0; m < 3; m++) begin
`ifdef DMEM_OUTREG_EN
            check_eq($sformatf("a_do[m%0d]", m), 32'(a_do[m]), 32'(ad2[m]));
            check_eq($sformatf("a_vld[m%0d]", m), 32'(a_vld[m]), 32'(av2[m]));
            check_eq($sformatf("b_do[m%0d]", m), 32'(b_do[m]), 32'(bd2));
            check_eq($sformatf("b_vld[m%0d]", m), 32'(b_vld[m]), 32'(bv2));
`else
            check_eq($sformatf("a_do[m%0d]", m), 32'(a_do[m]), 32'(ad1[m]));
            check_eq($sformatf("a_vld[m%0d]", m), 32'(a_vld[m]), 32'(av1[m]));
            check_eq($sformatf("b_do[m%0d]", m), 32'(b_do[m]), 32'(bd1));
            check_eq($sformatf("b_vld[m%0d]", m), 32'(b_vld[m]), 32'(bv1));
`endif
            check_eq($sformatf("busy[m%0d]", m), 32'(busy[m]), 32'(busy_left > 0));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle();
        a_en = 1'b0;
        a_we = '0;
        b_en = 1'b0;
    endtask

    task automatic settle();
        idle();
        repeat (Lat - 1) cycle();
    endtask

    task automatic write_a(input logic [AW-1:0] addr, input logic [NB-1:0] we,
                           input logic [DW-1:0] di);
        a_en = 1'b1; a_we = we; a_addr = addr; a_di = di;
        cycle();
        idle();
    endtask

    task automatic read_a(input logic [AW-1:0] addr);
        a_en = 1'b1; a_we = '0; a_addr = addr;
        cycle();
        settle();
    endtask

    task automatic read_b(input logic [AW-1:0] addr);
        b_en = 1'b1; b_addr = addr;
        cycle();
        settle();
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (busy[0] && n < 200) begin
            cycle();
            n++;
        end
        check_eq(tag, 32'(n), 32'(DEPTH));
    endtask

    task automatic random_a();
        a_en   = 1'($urandom);
        a_we   = NB'($urandom);
        a_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
        a_di   = DW'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; a_en = 1'b0; a_we = '0; a_addr = '0; a_di = '0;
        b_en = 1'b0; b_addr = '0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

        // Reset and full clear
        cycle();
        cycle();
        rst_n = 1'b1;
        wait_ready("clear_len");
        for (int i = 0; i < DEPTH; i++) begin
            read_b(AW'(i));
            check_eq("clear_zero", 32'(b_do[0]), 32'h0);
        end

        // Byte-enable merge
        write_a(6'd5, 2'b11, 16'hBEEF);
        write_a(6'd5, 2'b01, 16'h1234);
        read_a(6'd5);
        check_eq("merge_data", 32'(a_do[0]), 32'hBE34);
        check_eq("merge_vld", 32'(a_vld[0]), 32'h1);

        // Read-during-write modes
        write_a(6'd9, 2'b11, 16'h1111);
        read_a(6'd9);
        a_en = 1'b1; a_we = 2'b11; a_addr = 6'd9; a_di = 16'h2222;
        cycle();
        settle();
        check_eq("rdw_mode0", 32'(a_do[0]), 32'h1111);
        check_eq("rdw_mode1", 32'(a_do[1]), 32'h2222);
        check_eq("rdw_mode2_hold", 32'(a_do[2]), 32'h1111);
        check_eq("rdw_mode2_vld", 32'(a_vld[2]), 32'h0);

        // A/B same-address collision
        write_a(6'd3, 2'b11, 16'h5555);
        a_en = 1'b1; a_we = 2'b11; a_addr = 6'd3; a_di = 16'hAAAA;
        b_en = 1'b1; b_addr = 6'd3;
        cycle();
        settle();
        for (int m = 0; m < 3; m++) check_eq("collide_old", 32'(b_do[m]), 32'h5555);
        read_b(6'd3);
        check_eq("collide_new", 32'(b_do[0]), 32'hAAAA);

        // Random traffic on both ports
        for (int i = 0; i < 1500; i++) begin
            random_a();
            b_en   = 1'($urandom);
            b_addr = ($urandom_range(0, 1) == 0) ? a_addr : AW'($urandom_range(0, 7));
            cycle();
        end
        for (int i = 0; i < DEPTH; i++) write_a(AW'(i), 2'b11, DW'($urandom) | 16'h0001);

        // Reset mid-clear with port A activity while busy
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            random_a();
            b_en = 1'b1; b_addr = AW'($urandom);
            cycle();
            check_eq("busy_mid", 32'(busy[0]), 32'h1);
        end
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        a_en = 1'b1; a_we = 2'b11; a_di = 16'hFFFF;
        wait_ready("restart_len");
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            read_b(AW'(i));
            check_eq("reclear_zero", 32'(b_do[0]), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
